// File: rtl/pwm_deadtime_gate_driver_if.sv
// Gate-driver port bundle: raw PWM levels and controls in, complementary gate pairs out.
interface pwm_deadtime_gate_driver_if #(
    parameter int NUM_CH   = 3,
    parameter int DT_WIDTH = 8
);
    logic [NUM_CH-1:0]   pwm_in;
    logic [DT_WIDTH-1:0] dead_time;
    logic                enable;
    logic                fault_in;
    logic                fault_clear;
    logic [NUM_CH-1:0]   gate_hi;
    logic [NUM_CH-1:0]   gate_lo;
    logic                fault_latched;

    modport master (
        output pwm_in, dead_time, enable, fault_in, fault_clear,
        input  gate_hi, gate_lo, fault_latched
    );

    modport slave (
        input  pwm_in, dead_time, enable, fault_in, fault_clear,
        output gate_hi, gate_lo, fault_latched
    );
endinterface

// File: rtl/pwm_deadtime_gate_driver.sv
// Complementary high/low gate driver with per-channel dead time, enable gate and latched fault.
// Gates decode straight from registered FSM state, so a shoot-through pair cannot be formed.
module pwm_deadtime_gate_driver #(
    parameter int NUM_CH   = 3,
    parameter int DT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    pwm_deadtime_gate_driver_if.slave bus
);
    typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_HI, ST_LO} state_t;

    state_t              state_q [NUM_CH];
    state_t              state_d [NUM_CH];
    logic [DT_WIDTH-1:0] cnt_q   [NUM_CH];
    logic [DT_WIDTH-1:0] cnt_d   [NUM_CH];
    logic                fault_q;
    logic                fault_d;
    logic                force_off;

    always_comb begin
        // A fault present on this edge wins over a simultaneous clear.
        fault_d   = bus.fault_in ? 1'b1 : (bus.fault_clear ? 1'b0 : fault_q);
        force_off = bus.fault_in | fault_q | ~bus.enable;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (force_off) begin
                state_d[i] = ST_OFF;
            end else begin
                unique case (state_q[i])
                    ST_OFF: begin
                        state_d[i] = ST_DEAD;
                        cnt_d[i]   = bus.dead_time;
                    end
                    ST_HI: begin
                        if (!bus.pwm_in[i]) begin
                            state_d[i] = ST_DEAD;
                            cnt_d[i]   = bus.dead_time;
                        end
                    end
                    ST_LO: begin
                        if (bus.pwm_in[i]) begin
                            state_d[i] = ST_DEAD;
                            cnt_d[i]   = bus.dead_time;
                        end
                    end
                    ST_DEAD: begin
                        // Reversals inside the dead zone only change the exit target.
                        if (cnt_q[i] == '0) begin
                            state_d[i] = bus.pwm_in[i] ? ST_HI : ST_LO;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DT_WIDTH'(1);
                        end
                    end
                    default: state_d[i] = ST_OFF;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            fault_q <= fault_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        bus.gate_hi       = '0;
        bus.gate_lo       = '0;
        bus.fault_latched = fault_q;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.gate_hi[i] = (state_q[i] == ST_HI);
            bus.gate_lo[i] = (state_q[i] == ST_LO);
        end
    end

    a_no_shoot_through: assert property (
        @(posedge clk) disable iff (rst) ((bus.gate_hi & bus.gate_lo) == '0)
    );
endmodule

// File: tb/tb_pwm_deadtime_gate_driver.sv
// Bench for pwm_deadtime_gate_driver: directed timing scenarios plus a per-cycle scoreboard.
module tb_pwm_deadtime_gate_driver;
    localparam int NUM_CH = 3;
    localparam int DT_W   = 8;
    localparam logic [1:0] M_OFF = 2'd0, M_DEAD = 2'd1, M_HI = 2'd2, M_LO = 2'd3;

    typedef struct packed {
        logic [1:0]      st;
        logic [DT_W-1:0] cnt;
        logic [DT_W-1:0] dl;
    } ch_t;
    typedef ch_t [NUM_CH-1:0] chv_t;
    typedef struct packed {
        logic [NUM_CH-1:0] hi;
        logic [NUM_CH-1:0] lo;
        logic              fl;
    } exp_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    chv_t m_ch;
    logic m_fl;
    int   gap [NUM_CH];

    pwm_deadtime_gate_driver_if #(.NUM_CH(NUM_CH), .DT_WIDTH(DT_W)) bus ();

    pwm_deadtime_gate_driver #(.NUM_CH(NUM_CH), .DT_WIDTH(DT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic chv_t model_next(input chv_t cur, input logic fl, input logic [NUM_CH-1:0] p,
                                        input logic [DT_W-1:0] dt, input logic en, input logic fin);
        chv_t n;
        n = cur;
        for (int i = 0; i < NUM_CH; i++) begin
            if (fin || fl || !en) begin
                n[i].st = M_OFF;
            end else if (cur[i].st == M_OFF || (cur[i].st == M_HI && !p[i]) || (cur[i].st == M_LO && p[i])) begin
                n[i].st  = M_DEAD;
                n[i].cnt = dt;
                n[i].dl  = dt;
            end else if (cur[i].st == M_DEAD) begin
                if (cur[i].cnt == 0) n[i].st = p[i] ? M_HI : M_LO;
                else n[i].cnt = cur[i].cnt - 1'b1;
            end
        end
        return n;
    endfunction

    function automatic exp_t expect_of(input chv_t c, input logic fl);
        exp_t e;
        e.fl = fl;
        for (int i = 0; i < NUM_CH; i++) begin
            e.hi[i] = (c[i].st == M_HI);
            e.lo[i] = (c[i].st == M_LO);
        end
        return e;
    endfunction

    // Reference model: advances on every active edge and queues what the DUT must show afterwards.
    initial begin
        chv_t nx;
        logic nfl;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_ch = '0;
                m_fl = 1'b0;
                exp_q.delete();
                exp_q.push_back('0);
            end else begin
                nx   = model_next(m_ch, m_fl, bus.pwm_in, bus.dead_time, bus.enable, bus.fault_in);
                nfl  = bus.fault_in ? 1'b1 : (bus.fault_clear ? 1'b0 : m_fl);
                m_ch = nx;
                m_fl = nfl;
                exp_q.push_back(expect_of(m_ch, m_fl));
            end
        end
    end

    // Monitor on the falling edge: scoreboard pop, overlap check, and minimum dead-gap check.
    initial begin
        exp_t e;
        for (int i = 0; i < NUM_CH; i++) gap[i] = 0;
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty t=%0t no expected entry queued", $time);
            end else begin
                e = exp_q.pop_front();
                if ({bus.gate_hi, bus.gate_lo, bus.fault_latched} !== e) begin
                    errors++;
                    $display("FAIL sb_cycle t=%0t got hi=%b lo=%b fl=%b expected hi=%b lo=%b fl=%b",
                             $time, bus.gate_hi, bus.gate_lo, bus.fault_latched, e.hi, e.lo, e.fl);
                end
            end
            checks++;
            if ((bus.gate_hi & bus.gate_lo) !== '0) begin
                errors++;
                $display("FAIL overlap t=%0t hi=%b lo=%b required no common bit", $time, bus.gate_hi, bus.gate_lo);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.gate_hi[i] | bus.gate_lo[i]) begin
                    if (gap[i] > 0) begin
                        checks++;
                        if (gap[i] < int'(m_ch[i].dl) + 1) begin
                            errors++;
                            $display("FAIL dead_gap ch%0d t=%0t gap=%0d required>=%0d", i, $time, gap[i], int'(m_ch[i].dl) + 1);
                        end
                    end
                    gap[i] = 0;
                end else begin
                    gap[i]++;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++;
        if (bus.gate_hi !== 3'b000 || bus.gate_lo !== 3'b000 || bus.fault_latched !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got hi=%b lo=%b fl=%b required all 0", bus.gate_hi, bus.gate_lo, bus.fault_latched);
        end
        rst = 1'b0;
    endtask

    task automatic test_deadtime_d4();
        bus.dead_time = 8'd4;
        bus.pwm_in    = 3'b001;
        tick(12);
        checks++;
        if (bus.gate_hi[0] !== 1'b1) begin
            errors++;
            $display("FAIL d4_settled_hi got %b required 1", bus.gate_hi[0]);
        end
        bus.pwm_in[0] = 1'b0;
        tick();
        checks++;
        if (bus.gate_hi[0] !== 1'b0 || bus.gate_lo[0] !== 1'b0) begin
            errors++;
            $display("FAIL d4_hi_off got hi=%b lo=%b required 0 0", bus.gate_hi[0], bus.gate_lo[0]);
        end
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++;
            if (bus.gate_lo[0] !== 1'b0) begin
                errors++;
                $display("FAIL d4_gap_k+%0d got lo=%b required 0", j, bus.gate_lo[0]);
            end
        end
        tick();
        checks++;
        if (bus.gate_lo[0] !== 1'b1 || bus.gate_hi[0] !== 1'b0) begin
            errors++;
            $display("FAIL d4_lo_on got hi=%b lo=%b required 0 1", bus.gate_hi[0], bus.gate_lo[0]);
        end
    endtask

    task automatic test_d0_toggle();
        logic lvl;
        bus.dead_time = 8'd0;
        tick(4);
        for (int t = 0; t < 4; t++) begin
            bus.pwm_in[1] = ~bus.pwm_in[1];
            lvl = bus.pwm_in[1];
            tick();
            checks++;
            if (bus.gate_hi[1] !== 1'b0 || bus.gate_lo[1] !== 1'b0) begin
                errors++;
                $display("FAIL d0_gap t%0d got hi=%b lo=%b required 0 0", t, bus.gate_hi[1], bus.gate_lo[1]);
            end
            for (int j = 0; j < 5; j++) begin
                tick();
                checks++;
                if (bus.gate_hi[1] !== lvl || bus.gate_lo[1] !== ~lvl) begin
                    errors++;
                    $display("FAIL d0_on t%0d c%0d got hi=%b lo=%b required %b %b", t, j, bus.gate_hi[1], bus.gate_lo[1], lvl, ~lvl);
                end
            end
        end
    endtask

    task automatic test_reversal();
        bus.dead_time = 8'd6;
        bus.pwm_in[2] = 1'b1;
        tick(12);
        bus.pwm_in[2] = 1'b0;
        tick(2);
        bus.pwm_in[2] = 1'b1;
        for (int j = 2; j <= 6; j++) begin
            tick();
            checks++;
            if (bus.gate_hi[2] !== 1'b0 || bus.gate_lo[2] !== 1'b0) begin
                errors++;
                $display("FAIL rev_gap k+%0d got hi=%b lo=%b required 0 0", j, bus.gate_hi[2], bus.gate_lo[2]);
            end
        end
        tick();
        checks++;
        if (bus.gate_hi[2] !== 1'b1 || bus.gate_lo[2] !== 1'b0) begin
            errors++;
            $display("FAIL rev_hi_back got hi=%b lo=%b required 1 0", bus.gate_hi[2], bus.gate_lo[2]);
        end
    endtask

    task automatic test_fault();
        bus.dead_time = 8'd2;
        bus.pwm_in    = 3'b101;
        tick(10);
        bus.fault_in = 1'b1;
        tick();
        checks++;
        if (bus.gate_hi !== 3'b000 || bus.gate_lo !== 3'b000 || bus.fault_latched !== 1'b1) begin
            errors++;
            $display("FAIL fault_trip got hi=%b lo=%b fl=%b required 000 000 1", bus.gate_hi, bus.gate_lo, bus.fault_latched);
        end
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
        checks++;
        if (bus.fault_latched !== 1'b1) begin
            errors++;
            $display("FAIL fault_clear_ignored got fl=%b required 1", bus.fault_latched);
        end
        tick();
        bus.fault_in = 1'b0;
        tick(2);
        checks++;
        if (bus.fault_latched !== 1'b1 || bus.gate_hi !== 3'b000) begin
            errors++;
            $display("FAIL fault_held got fl=%b hi=%b required 1 000", bus.fault_latched, bus.gate_hi);
        end
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
        checks++;
        if (bus.fault_latched !== 1'b0 || bus.gate_hi !== 3'b000 || bus.gate_lo !== 3'b000) begin
            errors++;
            $display("FAIL fault_release got fl=%b hi=%b lo=%b required 0 000 000", bus.fault_latched, bus.gate_hi, bus.gate_lo);
        end
        for (int j = 1; j <= 3; j++) begin
            tick();
            checks++;
            if ((bus.gate_hi | bus.gate_lo) !== 3'b000) begin
                errors++;
                $display("FAIL fault_restart_gap c+%0d got hi=%b lo=%b required 000 000", j, bus.gate_hi, bus.gate_lo);
            end
        end
        tick();
        checks++;
        if (bus.gate_hi !== 3'b101 || bus.gate_lo !== 3'b010) begin
            errors++;
            $display("FAIL fault_restart_on got hi=%b lo=%b required 101 010", bus.gate_hi, bus.gate_lo);
        end
    endtask

    task automatic test_enable();
        bus.dead_time = 8'd3;
        bus.pwm_in    = 3'b011;
        tick(10);
        bus.enable = 1'b0;
        tick();
        checks++;
        if ((bus.gate_hi | bus.gate_lo) !== 3'b000) begin
            errors++;
            $display("FAIL en_off got hi=%b lo=%b required 000 000", bus.gate_hi, bus.gate_lo);
        end
        bus.enable = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if ((bus.gate_hi | bus.gate_lo) !== 3'b000) begin
                errors++;
                $display("FAIL en_dead c%0d got hi=%b lo=%b required 000 000", j, bus.gate_hi, bus.gate_lo);
            end
        end
        tick();
        checks++;
        if (bus.gate_hi !== 3'b011 || bus.gate_lo !== 3'b100) begin
            errors++;
            $display("FAIL en_on got hi=%b lo=%b required 011 100", bus.gate_hi, bus.gate_lo);
        end
    endtask

    task automatic test_async_reset();
        bus.dead_time = 8'd5;
        bus.pwm_in    = 3'b001;
        tick(12);
        bus.pwm_in = 3'b000;
        tick(2);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.gate_hi !== 3'b000 || bus.gate_lo !== 3'b000 || bus.fault_latched !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate got hi=%b lo=%b fl=%b required all 0", bus.gate_hi, bus.gate_lo, bus.fault_latched);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            checks++;
            if ((bus.gate_hi | bus.gate_lo) !== 3'b000) begin
                errors++;
                $display("FAIL arst_gap e%0d got hi=%b lo=%b required 000 000", j, bus.gate_hi, bus.gate_lo);
            end
        end
        tick();
        checks++;
        if (bus.gate_lo !== 3'b111 || bus.gate_hi !== 3'b000) begin
            errors++;
            $display("FAIL arst_first_on got hi=%b lo=%b required 000 111", bus.gate_hi, bus.gate_lo);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 20000; c++) begin
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 11) == 0) bus.pwm_in[i] = ~bus.pwm_in[i];
            if ($urandom_range(0, 49) == 0) bus.dead_time = DT_W'($urandom_range(0, 9));
            bus.fault_in    = ($urandom_range(0, 399) == 0);
            bus.fault_clear = ($urandom_range(0, 15) == 0);
            bus.enable      = ($urandom_range(0, 299) != 0);
            tick();
        end
        bus.fault_in    = 1'b0;
        bus.fault_clear = 1'b0;
        bus.enable      = 1'b1;
        tick(2);
    endtask

    initial begin
        rst             = 1'b0;
        bus.pwm_in      = '0;
        bus.dead_time   = '0;
        bus.enable      = 1'b1;
        bus.fault_in    = 1'b0;
        bus.fault_clear = 1'b0;
        #2;
        test_reset();
        test_deadtime_d4();
        test_d0_toggle();
        test_reversal();
        test_fault();
        test_enable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
